// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath definitions for the program-counter path.
//   PC_SRC_*         select encodings for the next-PC candidate mux
//   pc_fsm_e         PC load sequencer states
//   PC_RESET_VEC_DEF default PC after reset
//   PC_EXC_VEC_DEF   default PC loaded on a misaligned target
package cpu_pkg;

    localparam int PC_SRC_INC    = 0;
    localparam int PC_SRC_BRANCH = 1;
    localparam int PC_SRC_JUMP   = 2;
    localparam int PC_SRC_ALU    = 3;

    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_00FF;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pc_fsm_e;

endpackage

// File: rtl/pc_src_mux.sv
// pc_src_mux: combinational next-PC candidate selector.
//   sel     in   SEL_W          source select
//   data_in in   NUM_SRC*WIDTH  flattened candidates, src i = data_in[i*WIDTH +: WIDTH]
//   cand    out  WIDTH          selected candidate; sel >= NUM_SRC yields src 0
module pc_src_mux #(
    parameter  int WIDTH   = 32,
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]         cand
);

    // Start from src 0 so an unused select code never produces X.
    always_comb begin
        cand = data_in[WIDTH-1:0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                cand = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_update_unit.sv
// pc_update_unit: next-PC selection, alignment check and program-counter register.
//   clk           in   1              rising-edge clock
//   reset         in   1              synchronous, active-high
//   sel           in   SEL_W          source select
//   data_in       in   NUM_SRC*WIDTH  flattened candidates
//   pc_write      in   1              load request this cycle
//   stall         in   1              pipeline stall, PC frozen while high
//   pc_out        out  WIDTH          current PC
//   epc           out  WIDTH          PC at the time of the last misalign fault
//   misalign_exc  out  1              one-cycle pulse with the fault load
//   pending       out  1              a held write awaits stall release
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no deferred write; unstalled pc_write loads next edge
// PENDING | a pc_write arrived under stall; hold keeps the latest cand
module pc_update_unit
    import cpu_pkg::*;
#(
    parameter  int               WIDTH      = 32,
    parameter  int               NUM_SRC    = 4,
    localparam int               SEL_W      = $clog2(NUM_SRC),
    parameter  int               ALIGN_BITS = 2,
    parameter  logic [WIDTH-1:0] RESET_VEC  = WIDTH'(PC_RESET_VEC_DEF),
    parameter  logic [WIDTH-1:0] EXC_VEC    = WIDTH'(PC_EXC_VEC_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] data_in,
    input  logic                     pc_write,
    input  logic                     stall,
    output logic [WIDTH-1:0]         pc_out,
    output logic [WIDTH-1:0]         epc,
    output logic                     misalign_exc,
    output logic                     pending
);

    // An all-zero mask (ALIGN_BITS == 0) disables the alignment check.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    pc_fsm_e          state, state_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] load_val;
    logic             load_en;
    logic             misaligned;

    pc_src_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) u_src_mux (
        .sel     (sel),
        .data_in (data_in),
        .cand    (cand)
    );

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        load_en   = 1'b0;
        load_val  = cand;
        case (state)
            IDLE: begin
                if (pc_write) begin
                    if (stall) begin
                        hold_nxt  = cand;
                        state_nxt = PENDING;
                    end else begin
                        load_en = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (stall) begin
                    if (pc_write) begin
                        hold_nxt = cand;
                    end
                end else begin
                    // A fresh request at release supersedes the held one.
                    load_en   = 1'b1;
                    load_val  = pc_write ? cand : hold;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Checked on the value actually loaded, so a held target is judged at release.
    assign misaligned = |(load_val & ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold         <= '0;
            pc_out       <= RESET_VEC;
            epc          <= '0;
            misalign_exc <= 1'b0;
            pending      <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold         <= hold_nxt;
            pending      <= (state_nxt == PENDING);
            misalign_exc <= load_en && misaligned;
            if (load_en) begin
                if (misaligned) begin
                    pc_out <= EXC_VEC;
                    epc    <= pc_out;
                end else begin
                    pc_out <= load_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_update_unit.sv
module tb_pc_update_unit;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   sel;
    logic [127:0] data_in;
    logic         pc_write;
    logic         stall;
    logic [31:0]  pc_out, epc;
    logic         misalign_exc, pending;

    logic [1:0]   sel3;
    logic [95:0]  data3;
    logic [31:0]  pc3, epc3;
    logic         exc3, pend3;

    logic [31:0]  pc_na, epc_na;
    logic         exc_na, pend_na;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_update_unit dut (
        .clk(clk), .reset(reset), .sel(sel), .data_in(data_in),
        .pc_write(pc_write), .stall(stall), .pc_out(pc_out), .epc(epc),
        .misalign_exc(misalign_exc), .pending(pending)
    );

    pc_update_unit #(.NUM_SRC(3)) dut3 (
        .clk(clk), .reset(reset), .sel(sel3), .data_in(data3),
        .pc_write(pc_write), .stall(stall), .pc_out(pc3), .epc(epc3),
        .misalign_exc(exc3), .pending(pend3)
    );

    pc_update_unit #(.ALIGN_BITS(0)) dut_na (
        .clk(clk), .reset(reset), .sel(sel), .data_in(data_in),
        .pc_write(pc_write), .stall(stall), .pc_out(pc_na), .epc(epc_na),
        .misalign_exc(exc_na), .pending(pend_na)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sweep_exp  [4] = '{32'h04, 32'h10, 32'h20, 32'h30};
    logic [31:0] sweep3_exp [4] = '{32'h04, 32'h08, 32'h0C, 32'h04};

    initial begin
        reset    = 1'b1;
        pc_write = 1'b1;
        stall    = 1'b0;
        sel      = 2'd0;
        sel3     = 2'd0;
        data_in  = {32'h30, 32'h20, 32'h10, 32'h04};
        data3    = {32'h0C, 32'h08, 32'h04};

        // Reset held two cycles with pc_write asserted.
        tick();
        tick();
        check_val("rst_pc",      pc_out, 32'h0);
        check_val("rst_pending", 32'(pending), 32'h0);
        check_val("rst_exc",     32'(misalign_exc), 32'h0);
        check_val("rst_epc",     epc, 32'h0);

        // Select sweep; the 3-source instance maps sel=3 back to src 0.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel  = 2'(i);
            sel3 = 2'(i);
            tick();
            check_val($sformatf("sweep_sel%0d", i), pc_out, sweep_exp[i]);
            check_val($sformatf("sweep3_sel%0d", i), pc3, sweep3_exp[i]);
        end
        check_val("sweep_pc_alias", 32'(sel), 32'(PC_SRC_ALU));

        // Stall hold, latest write wins, released with pc_write low.
        sel   = 2'(PC_SRC_INC);
        stall = 1'b1;
        data_in[31:0] = 32'h40;
        tick();
        check_val("stall_pend1", 32'(pending), 32'h1);
        check_val("stall_pc1",   pc_out, 32'h30);
        data_in[31:0] = 32'h80;
        tick();
        check_val("stall_pend2", 32'(pending), 32'h1);
        check_val("stall_pc2",   pc_out, 32'h30);
        pc_write = 1'b0;
        data_in[31:0] = 32'h1234;
        tick();
        check_val("stall_pc3",   pc_out, 32'h30);
        stall = 1'b0;
        tick();
        check_val("release_pc",   pc_out, 32'h80);
        check_val("release_pend", 32'(pending), 32'h0);

        // Release with a fresh write overrides the held value.
        stall    = 1'b1;
        pc_write = 1'b1;
        data_in[31:0] = 32'h80;
        tick();
        check_val("ovr_pend", 32'(pending), 32'h1);
        stall = 1'b0;
        data_in[31:0] = 32'h100;
        tick();
        check_val("ovr_pc",   pc_out, 32'h100);
        check_val("ovr_pend0", 32'(pending), 32'h0);

        // Misaligned direct load.
        data_in[31:0] = 32'h20;
        tick();
        check_val("mis_pre_pc", pc_out, 32'h20);
        data_in[31:0] = 32'h22;
        tick();
        check_val("mis_pc",    pc_out, 32'hFF);
        check_val("mis_epc",   epc, 32'h20);
        check_val("mis_exc",   32'(misalign_exc), 32'h1);
        check_val("na_pc",     pc_na, 32'h22);
        check_val("na_exc",    32'(exc_na), 32'h0);
        pc_write = 1'b0;
        tick();
        check_val("mis_exc_off", 32'(misalign_exc), 32'h0);
        check_val("mis_pc_hold", pc_out, 32'hFF);

        // Misaligned held value faults at release.
        pc_write = 1'b1;
        data_in[31:0] = 32'h40;
        tick();
        check_val("hmis_pre_pc", pc_out, 32'h40);
        stall = 1'b1;
        data_in[31:0] = 32'h46;
        tick();
        check_val("hmis_no_exc", 32'(misalign_exc), 32'h0);
        stall    = 1'b0;
        pc_write = 1'b0;
        tick();
        check_val("hmis_pc",  pc_out, 32'hFF);
        check_val("hmis_epc", epc, 32'h40);
        check_val("hmis_exc", 32'(misalign_exc), 32'h1);

        // Reset while PENDING discards the held write.
        stall    = 1'b1;
        pc_write = 1'b1;
        data_in[31:0] = 32'h40;
        tick();
        check_val("rp_pend", 32'(pending), 32'h1);
        reset = 1'b1;
        tick();
        check_val("rp_rst_pc",   pc_out, 32'h0);
        check_val("rp_rst_pend", 32'(pending), 32'h0);
        reset    = 1'b0;
        stall    = 1'b0;
        pc_write = 1'b0;
        tick();
        tick();
        check_val("rp_after_pc",   pc_out, 32'h0);
        check_val("rp_after_pend", 32'(pending), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
